// File: rtl/instr_stream_encoder_pkg.sv
// +----------------------------------------------------------------------+
// | instr_pkg: opcodes, error codes and FSM encoding for the encoder     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package instr_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_BNE = 4'd14;
  localparam logic [3:0] OP_JMP = 4'd15;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_stream_encoder_opcode_legal_check.sv
// +----------------------------------------------------------------------+
// | opcode_legal_check: flags whether a 4-bit opcode is implemented      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module opcode_legal_check
  import instr_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
      OP_LW, OP_SW, OP_BNE, OP_JMP: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_stream_encoder.sv
// +----------------------------------------------------------------------+
// | instr_stream_encoder: packs instruction field beats into 16-bit      |
// | words and writes them sequentially into instruction memory.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_stream_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_f1,
  input  logic [3:0]        in_f2,
  input  logic [3:0]        in_f3,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [3:0]        err_opcode,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(BASE_ADDR + DEPTH - 1);

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   w_legal;
  logic   w_accept;
  logic   w_at_last;

  opcode_legal_check u_legal (
    .opcode (in_opcode),
    .legal  (w_legal)
  );

  assign w_accept  = in_valid && in_ready;
  assign w_at_last = (mem_addr == C_LAST);
  assign mem_we    = (r_state == S_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ACCEPT;
      S_ACCEPT: if (w_accept) w_next = w_legal ? S_WRITE : S_DONE;
      S_WRITE:  w_next = (r_last || w_at_last) ? S_DONE : S_ACCEPT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Handshake/status outputs are registered off the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= ERR_NONE;
      err_opcode <= 4'd0;
      count      <= '0;
      mem_addr   <= C_BASE;
      mem_wdata  <= 16'd0;
      r_last     <= 1'b0;
    end else begin
      in_ready <= (w_next == S_ACCEPT);
      busy     <= (w_next != S_IDLE);
      done     <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            err        <= ERR_NONE;
            err_opcode <= 4'd0;
            count      <= '0;
            mem_addr   <= C_BASE;
          end
        end
        S_ACCEPT: begin
          if (w_accept) begin
            if (w_legal) begin
              mem_wdata <= {in_opcode, in_f1, in_f2, in_f3};
              r_last    <= in_last;
            end else begin
              err        <= ERR_ILLEGAL;
              err_opcode <= in_opcode;
            end
          end
        end
        S_WRITE: begin
          count <= count + (ADDR_W+1)'(1);
          // A last beat landing on the final address ends cleanly.
          if (!r_last) begin
            if (w_at_last) begin
              err <= ERR_OVERFLOW;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Write side of the 4-bit-opcode instruction format used by the single-cycle 16-bit core.
- Accepts decoded instruction fields (opcode plus three 4-bit fields) over a valid/ready handshake.
- Checks each opcode against the legal opcode set, packs the fields into 16-bit instruction words and writes them sequentially into instruction memory.
- Used by the bench and debug loader to fill instruction memory before the core is released from reset.

Parameters:
- ADDR_W, 8, instruction memory address width.
- BASE_ADDR, 0, first address written after each start.
- DEPTH, 256, number of writable words starting at BASE_ADDR. BASE_ADDR+DEPTH must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load session. Ignored unless in IDLE.
- in_valid  in  1  field beat valid.
- in_ready  out  1  encoder can accept a beat.
- in_opcode  in  4  opcode, bits [15:12] of the word.
- in_f1  in  4  bits [11:8]: rs.
- in_f2  in  4  bits [7:4]: rt.
- in_f3  in  4  bits [3:0]: rd, imm4 or offset.
- in_last  in  1  marks the final beat of the session.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  packed word {opcode,f1,f2,f3}.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at session end.
- err  out  2  sticky error code for the session: 00 none, 01 illegal opcode, 10 overflow.
- err_opcode  out  4  opcode that caused error 01.
- count  out  ADDR_W+1  words written in the current or last session.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; mem_addr=BASE_ADDR; state IDLE. A pending write is dropped, so mem_we is never asserted for a beat accepted before reset.
- Legal opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 8 LW, 10 SW, 14 BNE, 15 JMP. All other values are illegal.
- Packing is uniform: mem_wdata = {in_opcode,in_f1,in_f2,in_f3}. For JMP, {f1,f2,f3} is the 12-bit target.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On start: clear err, err_opcode and count; set mem_addr=BASE_ADDR; go to ACCEPT.
- ACCEPT:
  - in_ready=1. A beat is accepted only when in_valid && in_ready.
  - Legal opcode: register the packed word and in_last, go to WRITE.
  - Illegal opcode: err=01, err_opcode=in_opcode, no write, go to DONE.
- WRITE (exactly one cycle):
  - in_ready=0; mem_we=1 with the registered mem_addr and mem_wdata; count+1.
  - If the registered last flag is set: go to DONE.
  - Else if mem_addr==BASE_ADDR+DEPTH-1: err=10, go to DONE. The word just written is kept.
  - Else: mem_addr+1, go to ACCEPT.
- DONE: done=1 for one cycle; go to IDLE. err, err_opcode and count hold until the next start.
- Latency and throughput: beat accepted in cycle N, written in cycle N+1, next beat accepted no earlier than N+2. Maximum rate is one word per 2 cycles.
- Boundary cases:
  - in_valid outside ACCEPT is ignored. The source must hold the beat until in_ready.
  - start while busy is ignored.
  - in_last on an illegal beat: the illegal-opcode error wins and nothing is written.
  - in_last on the word at the final address: no error, normal DONE.
  - count never exceeds DEPTH. mem_addr never wraps.
- mem_we is combinational from state only. All other outputs are registered.

Decomposition:
- Package instr_pkg holds:
  - opcode localparams: OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=6, OP_SLT=7, OP_LW=8, OP_SW=10, OP_BNE=14, OP_JMP=15;
  - err code constants ERR_NONE, ERR_ILLEGAL, ERR_OVERFLOW;
  - FSM state encoding.
- One sub-module, opcode_legal_check: combinational, 4-bit opcode in, 1-bit legal out. It is shared with future decoder-side assertion checkers.

Test Plan:
- Reset, start, then beats {2,1,2,3}, {8,4,5,0}, {15,0,1,0} with last on the third beat:
  - mem writes 0x2123 @0, 0x8450 @1, 0xF010 @2;
  - count=3, err=00, done pulses once, busy falls the cycle after done.
- Beat sequence {0,…} then {3,1,1,1}:
  - exactly one write (@0);
  - err=01, err_opcode=3, count=1, no write for opcode 3.
- DEPTH=4 override, 6 beats without last:
  - writes @0..@3;
  - err=10 after the 4th write, done pulses, beats 5–6 are never accepted.
- Back-pressure: in_valid held high continuously:
  - in_ready toggles 1,0,1,0;
  - one write per 2 cycles, no duplicated or lost words (checked against a scoreboard).
- rst_n asserted in the cycle after a beat is accepted (WRITE pending):
  - mem_we stays 0, all outputs go to 0 immediately, next start begins at BASE_ADDR.
- start pulsed while in ACCEPT, plus in_valid pulsed in IDLE:
  - both ignored; session state and count unchanged.
